// File: rtl/rx_frame_filter_fifo_if.sv
// Avalon-ST style receive and transmit streams of the frame filter FIFO.
// The slave modport is the FIFO itself; the master modport is its environment
// (MAC on the receive side, frame-processing core on the transmit side).
interface rx_frame_filter_fifo_if #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int ERR_W   = 6
);
    // Receive side (MAC -> FIFO)
    logic [DATA_W-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    logic               in_sop;
    logic               in_eop;
    logic [EMPTY_W-1:0] in_empty;
    logic [ERR_W-1:0]   in_error;

    // Transmit side (FIFO -> core)
    logic [DATA_W-1:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_sop;
    logic               out_eop;
    logic [EMPTY_W-1:0] out_empty;

    modport slave (
        input  in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_empty
    );

    modport master (
        output in_data, in_valid, in_sop, in_eop, in_empty, in_error, out_ready,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_empty
    );
endinterface

// File: rtl/rx_frame_filter_fifo.sv
// Store-and-forward receive frame buffer. Whole frames are written into a RAM
// behind a commit pointer; clean frames are committed and streamed out, while
// errored, malformed or overflowing frames are rewound to the commit pointer.
module rx_frame_filter_fifo #(
    parameter int DATA_W  = 32,
    parameter int EMPTY_W = 2,
    parameter int ERR_W   = 6,
    parameter int ADDR_W  = 9,
    parameter int CNT_W   = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    rx_frame_filter_fifo_if.slave bus,
    output logic [CNT_W-1:0]      frames_passed,
    output logic [CNT_W-1:0]      frames_dropped
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STORE,
        ST_DISCARD
    } wr_state_t;

    // Write side
    wr_state_t         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  base_ptr;
    logic              base_full;
    logic              in_ready_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    entry_t            mem_wdata;
    logic [ERR_W-1:0]  err_vec;
    logic              pass_inc;
    logic [1:0]        drop_inc;
    logic [CNT_W-1:0]  passed_q, dropped_q;

    // Read side
    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    entry_t            ram_rd_q;
    logic              ram_vld_q;
    entry_t            out_q, skid_q;
    logic              out_valid_q, skid_valid_q;
    logic              pop;
    logic              avail;
    logic [1:0]        occ;
    logic              rd_en;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign err_vec   = bus.in_error;
    assign mem_wdata = '{data: bus.in_data, sop: bus.in_sop, eop: bus.in_eop,
                         empty: bus.in_empty};

    // Write FSM next state: decide where the incoming word goes and whether
    // the frame in progress is committed, rewound or discarded.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can leave it unassigned and infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        base_ptr     = wr_ptr_q;
        base_full    = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = '0;
        pass_inc     = 1'b0;
        drop_inc     = 2'd0;

        if (in_ready_q && bus.in_valid) begin
            if (state_q == ST_STORE || bus.in_sop) begin
                // A sop while a frame is open aborts that frame.
                if (state_q == ST_STORE && bus.in_sop) begin
                    drop_inc = drop_inc + 2'd1;
                end
                // A new frame always starts at the commit point.
                base_ptr  = bus.in_sop ? commit_ptr_q : wr_ptr_q;
                base_full = (base_ptr - rd_ptr_q) == DEPTH_P;

                if (base_full) begin
                    wr_ptr_d = commit_ptr_q;
                    if (bus.in_eop) begin
                        drop_inc = drop_inc + 2'd1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DISCARD;
                    end
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = base_ptr[ADDR_W-1:0];
                    if (bus.in_eop) begin
                        state_d = ST_IDLE;
                        if (err_vec != '0) begin
                            wr_ptr_d = commit_ptr_q;
                            drop_inc = drop_inc + 2'd1;
                        end else begin
                            wr_ptr_d     = base_ptr + 1'b1;
                            commit_ptr_d = base_ptr + 1'b1;
                            pass_inc     = 1'b1;
                        end
                    end else if (bus.in_empty != '0) begin
                        // Partial word in mid-frame: malformed, drop the rest.
                        wr_ptr_d = commit_ptr_q;
                        drop_inc = drop_inc + 2'd1;
                        state_d  = ST_DISCARD;
                    end else begin
                        wr_ptr_d = base_ptr + 1'b1;
                        state_d  = ST_STORE;
                    end
                end
            end else if (state_q == ST_DISCARD && bus.in_eop) begin
                drop_inc = drop_inc + 2'd1;
                state_d  = ST_IDLE;
            end
        end
    end

    // Write FSM state, pointers, statistics and the always-ready flag.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            in_ready_q   <= 1'b0;
            passed_q     <= '0;
            dropped_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            in_ready_q   <= 1'b1;
            passed_q     <= sat_add(passed_q, {1'b0, pass_inc});
            dropped_q    <= sat_add(dropped_q, drop_inc);
        end
    end

    // Frame RAM with one-cycle registered read.
    always_ff @(posedge sys_clk) begin
        // NOTE: the RAM array and its read register carry no reset; pointers and valid flags decide what is meaningful.
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (rd_en) begin
            ram_rd_q <= mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    // Read credit: issue only if the word landing next cycle has a slot
    // (output register or skid) after this cycle's consumption.
    assign pop   = out_valid_q & bus.out_ready;
    assign avail = rd_ptr_q != commit_ptr_q;
    assign occ   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, ram_vld_q} - {1'b0, pop};
    assign rd_en = avail && (occ < 2'd2);

    // Read pointer, RAM-valid pipeline stage, output register and skid entry.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q     <= '0;
            ram_vld_q    <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            ram_vld_q <= rd_en;
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end

            if (!out_valid_q || pop) begin
                if (skid_valid_q) begin
                    out_q        <= skid_q;
                    out_valid_q  <= 1'b1;
                    skid_valid_q <= ram_vld_q;
                    if (ram_vld_q) begin
                        skid_q <= ram_rd_q;
                    end
                end else if (ram_vld_q) begin
                    out_q       <= ram_rd_q;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end else if (ram_vld_q) begin
                // Output is stalled: park the landing word in the skid.
                skid_q       <= ram_rd_q;
                skid_valid_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_q.data;
    assign bus.out_sop   = out_q.sop;
    assign bus.out_eop   = out_q.eop;
    assign bus.out_empty = out_q.empty;

    assign frames_passed  = passed_q;
    assign frames_dropped = dropped_q;

endmodule
